ysyx_23060075_adder_alu_seq: RTL and testbench
==============================================

# ysyx_23060075_adder_alu_seq

Multi-cycle, parametrised add/sub/compare unit that processes operands in `chunk_len`-bit slices, one slice per clock, through a carry chain held in a register. It generalises the single-cycle adder ALU with ready/valid handshakes, selectable chunking for timing closure, and signed/unsigned set-less-than modes. It sits in the NPC execute stage as the shared integer add/compare resource.

## Interface

Parameters:
- `data_len`, default 32: operand and result width.
- `chunk_len`, default 8: slice width per cycle. Must divide `data_len` evenly, with 1 ≤ `chunk_len` ≤ `data_len`. Slice count N = `data_len`/`chunk_len`.

Ports:
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request.
- `a` input `data_len`: operand A.
- `b` input `data_len`: operand B.
- `op` input 2: operation code.
  - 00 = add
  - 01 = sub
  - 10 = slt (signed)
  - 11 = sltu (unsigned)
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `result` output `data_len`: final result.
- `carry` output 1: unsigned carry for add; borrow for sub/slt/sltu.
- `overflow` output 1: signed overflow of the underlying add/sub.
- `zero` output 1: `result` == 0.

## Operation

- The FSM has three states.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `a`, `b`, `op` and go to CALC. Clear the slice index to 0 and preset the carry register to `is_sub` (`is_sub` = `op`≠00).
- CALC: each cycle, compute slice k as a[k] + (b[k] ^ {`is_sub`}) + carry_reg. Write the sum into the partial register and the slice carry-out into carry_reg, then increment k. After slice N-1, load the output registers and go to DONE.
- DONE: `out_valid`=1. On `out_valid && out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. There is no accept in the same cycle as DONE→IDLE. Input changes after capture are ignored.
- Output register load on the CALC→DONE transition:
  - sum = full N-slice sum; cout = final slice carry-out.
  - `carry` = cout ^ `is_sub`.
  - `overflow` = (A msb == B' msb) && (sum msb ≠ A msb), where B' is b after the `is_sub` inversion.
  - add/sub: `result` = sum.
  - slt: `result` = {0…, sum msb ^ `overflow`}.
  - sltu: `result` = {0…, `carry`}.
  - `zero` = (`result` == 0), computed on the final `result`.
- All arithmetic wraps modulo 2^`data_len`. No saturation.
- `result`, `carry`, `overflow`, `zero` change only on the CALC→DONE transition. They hold their last value through IDLE and the next CALC.
- When N=1, CALC lasts exactly one cycle. The module behaves as a registered single-cycle ALU with the same handshake.

## Timing

- Reset, sampled at an edge with `rst_n`=0:
  - State becomes IDLE from any state, including mid-CALC or DONE. The in-flight operation is discarded with no `out_valid` pulse.
  - After the edge: `in_ready`=1, `out_valid`=0, `result`=0, `carry`=0, `overflow`=0, `zero`=0. Slice index and carry_reg are cleared.
  - While `rst_n` is low, `in_ready` is held 0.
- Latency: for a request accepted at edge E0, `out_valid` is first 1 in the cycle after edge E0+N (N cycles of CALC). Examples: N=4 gives 4 cycles; N=1 gives 1 cycle.
- Throughput: one request per N+2 cycles at best (accept, N CALC, DONE handshake, back in IDLE).
- Backpressure: `out_valid` and all result outputs stay stable while `out_ready`=0, for any number of cycles.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.

## Test plan

Parameters for scenarios 1–5: `data_len`=32, `chunk_len`=8.

1. add `a`=0xFFFFFFFF, `b`=0x00000001 → `result`=0, `carry`=1, `overflow`=0, `zero`=1. `out_valid` rises exactly 4 cycles after the accepting edge.
2. sub `a`=0x80000000, `b`=1 → `result`=0x7FFFFFFF, `carry`=0, `overflow`=1, `zero`=0. Then sub 0−1 → 0xFFFFFFFF, `carry`=1, `overflow`=0.
3. slt `a`=0xFFFFFFFF, `b`=1 → `result`=1. sltu with the same operands → `result`=0, `carry`=0. slt `a`=0x80000000, `b`=0x7FFFFFFF → `result`=1, `overflow`=1.
4. Backpressure and stray inputs: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `result` stay stable, `in_ready`=0. Pulse `in_valid` with new operands during CALC → ignored; the result still matches the first request. Then raise `out_ready` → IDLE next cycle, `in_ready`=1.
5. Reset mid-CALC: drop `rst_n` during slice 2 → after that edge, `out_valid`=0, `in_ready`=0 while low, then `in_ready`=1 and `result`=0. A fresh add 3+4 → 7 with normal latency.
6. Alternate instance `data_len`=16, `chunk_len`=16: add 0x7FFF+1 → 0x8000, `overflow`=1, latency 1 cycle. Random add/sub/slt/sltu over 1000 requests with random `out_ready` stalls → matches a golden model.

Source files
------------

// File: rtl/ysyx_23060075_adder_alu_seq.sv
// Multi-cycle add/sub/slt/sltu unit. Operands are processed chunk_len bits
// per clock, least significant slice first. The carry between slices is
// held in a register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and is forced low while rst_n is
// low. out_valid is high only in DONE. Once out_valid is high, it and all
// result outputs hold steady until out_ready is seen high.
module ysyx_23060075_adder_alu_seq #(
  parameter int data_len  = 32,
  parameter int chunk_len = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_len-1:0] a,
  input  logic [data_len-1:0] b,
  input  logic [1:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_len-1:0] result,
  output logic                carry,
  output logic                overflow,
  output logic                zero
);

  localparam int n_slices = data_len / chunk_len;
  localparam int idx_w    = (n_slices > 1) ? $clog2(n_slices) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(n_slices - 1);

  localparam logic [1:0] op_add  = 2'b00;
  localparam logic [1:0] op_slt  = 2'b10;
  localparam logic [1:0] op_sltu = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The FSM state is kept as a named enum so that checkers can bind to it.
  state_t state;

  logic [data_len-1:0] a_q;
  logic [data_len-1:0] b_q;        // b, already inverted for subtract-type ops
  logic [data_len-1:0] partial;    // sum slices completed so far
  logic [1:0]          op_q;
  logic                is_sub_q;
  logic [idx_w-1:0]    idx;
  logic                carry_reg;

  logic [chunk_len:0]  slice_sum;
  logic [data_len-1:0] full_sum;
  logic                sum_msb;
  logic                carry_next;
  logic                ovf_next;
  logic [data_len-1:0] result_next;

  // Add the current slice, and merge it into the running sum so that the
  // complete sum is available during the final slice.
  always_comb begin
    slice_sum = {1'b0, a_q[int'(idx) * chunk_len +: chunk_len]}
              + {1'b0, b_q[int'(idx) * chunk_len +: chunk_len]}
              + {{chunk_len{1'b0}}, carry_reg};
    full_sum = partial;
    full_sum[int'(idx) * chunk_len +: chunk_len] = slice_sum[chunk_len-1:0];
  end

  // Derive the result outputs from the complete sum. These values are used
  // only on the last CALC cycle.
  always_comb begin
    sum_msb    = full_sum[data_len-1];
    carry_next = slice_sum[chunk_len] ^ is_sub_q;
    ovf_next   = (a_q[data_len-1] == b_q[data_len-1]) && (sum_msb != a_q[data_len-1]);
    case (op_q)
      op_slt:  result_next = {{(data_len-1){1'b0}}, sum_msb ^ ovf_next};
      op_sltu: result_next = {{(data_len-1){1'b0}}, carry_next};
      default: result_next = full_sum;
    endcase
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);

  // Control FSM, slice datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      partial   <= '0;
      op_q      <= op_add;
      is_sub_q  <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= (op != op_add) ? ~b : b;
            op_q      <= op;
            is_sub_q  <= (op != op_add);
            carry_reg <= (op != op_add);
            partial   <= '0;
            idx       <= '0;
            state     <= CALC;
          end
        end
        CALC: begin
          partial   <= full_sum;
          carry_reg <= slice_sum[chunk_len];
          if (idx == last_idx) begin
            idx      <= '0;
            result   <= result_next;
            carry    <= carry_next;
            overflow <= ovf_next;
            zero     <= (result_next == '0);
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060075_adder_alu_seq.sv
// Bench for the sliced add/compare unit. There are two instances. The first is
// a 32-bit unit with 8-bit slices. The second is a 16-bit unit with one slice.
// A select signal chooses which instance is driven and observed.
module tb_ysyx_23060075_adder_alu_seq;

  localparam int EW = 35; // {result[31:0], carry, overflow, zero}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- stimulus signals ----------------
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [1:0]  op = 2'b00;

  logic        ua_in_ready, ua_out_valid, ua_carry, ua_ovf, ua_zero;
  logic [31:0] ua_result;
  logic        ub_in_ready, ub_out_valid, ub_carry, ub_ovf, ub_zero;
  logic [15:0] ub_result;

  ysyx_23060075_adder_alu_seq #(.data_len(32), .chunk_len(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && !sel), .in_ready(ua_in_ready),
    .a(a_in), .b(b_in), .op(op),
    .out_valid(ua_out_valid), .out_ready(out_ready),
    .result(ua_result), .carry(ua_carry), .overflow(ua_ovf), .zero(ua_zero)
  );

  ysyx_23060075_adder_alu_seq #(.data_len(16), .chunk_len(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel), .in_ready(ub_in_ready),
    .a(a_in[15:0]), .b(b_in[15:0]), .op(op),
    .out_valid(ub_out_valid), .out_ready(out_ready),
    .result(ub_result), .carry(ub_carry), .overflow(ub_ovf), .zero(ub_zero)
  );

  // View of the currently selected instance.
  logic        v_in_ready, v_out_valid;
  logic [EW-1:0] v_out;
  int          w_cur, n_cur;
  assign v_in_ready  = sel ? ub_in_ready  : ua_in_ready;
  assign v_out_valid = sel ? ub_out_valid : ua_out_valid;
  assign v_out = sel ? {16'h0, ub_result, ub_carry, ub_ovf, ub_zero}
                     : {ua_result, ua_carry, ua_ovf, ua_zero};
  assign w_cur = sel ? 16 : 32;
  assign n_cur = sel ? 1 : 4;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at cycle %0d", name, cyc);
  endtask

  // Reference model. It uses plain w-bit arithmetic and comparisons.
  function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o, input int w);
    logic [63:0] mask, aa, bb, s;
    logic [31:0] r;
    logic sa, sb, c, v, lt_u, lt_s;
    mask = (64'd1 << w) - 64'd1;
    aa = {32'h0, a} & mask;
    bb = {32'h0, b} & mask;
    sa = aa[w-1];
    sb = bb[w-1];
    lt_u = (aa < bb);
    lt_s = (sa != sb) ? sa : lt_u;
    if (o == 2'b00) begin
      s = aa + bb;
      c = s[w];
      v = (sa == sb) && (s[w-1] != sa);
      r = s[31:0] & mask[31:0];
    end else begin
      s = (aa - bb) & mask;
      c = lt_u;
      v = (sa != sb) && (s[w-1] != sa);
      case (o)
        2'b01:   r = s[31:0];
        2'b10:   r = {31'h0, lt_s};
        default: r = {31'h0, lt_u};
      endcase
    end
    return {r, c, v, (r == 32'h0)};
  endfunction

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  logic [EW-1:0] held = '0;
  logic          prev_valid = 1'b0;

  // Compare process. It runs on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_in_reset", {34'h0, v_in_ready}, '0);
      exp_q.delete();
      acc_q.delete();
      held = '0;
      prev_valid = 1'b0;
    end else begin
      if (in_valid && v_in_ready) begin
        exp_q.push_back(model(a_in, b_in, op, w_cur));
        acc_q.push_back(cyc + 1);
      end
      if (v_out_valid) begin
        chk("in_ready_in_done", {34'h0, v_in_ready}, '0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {34'h0, v_out_valid}, '0);
        end else begin
          chk("result_outputs", v_out, exp_q[0]);
          if (!prev_valid) chk("latency", EW'(cyc - acc_q[0]), EW'(n_cur));
          if (out_ready) begin
            held = exp_q.pop_front();
            void'(acc_q.pop_front());
          end
        end
      end else begin
        chk("held_outputs", v_out, held);
      end
      prev_valid = v_out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    int t;
    t = 0;
    a_in = a;
    b_in = b;
    op = o;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (v_in_ready) break;
      t++;
      if (t > 50) begin
        fail_timeout("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (v_out_valid) break;
      t++;
      if (t > 50) begin
        fail_timeout("out_valid");
        break;
      end
    end
  endtask

  task automatic wait_hs(input bit rnd_stall);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (v_out_valid && out_ready) break;
      t++;
      if (t > 200) begin
        fail_timeout("handshake");
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Directed request with hand-computed literal expectations.
  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] o, input logic [31:0] er, input logic ec,
                     input logic eo, input logic ez);
    out_ready = 1'b1;
    send(a, b, o);
    wait_valid();
    chk(name, v_out, {er, ec, eo, ez});
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return m;
      2:       return 32'h1 << (w - 1);
      3:       return m >> 1;
      default: return $urandom() & m;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {34'h0, v_in_ready}, 35'h1);
    chk("reset_out_valid", {34'h0, v_out_valid}, '0);
    chk("reset_outputs_a", v_out, '0);
    chk("reset_outputs_b", {19'h0, ub_result}, '0);
    @(posedge clk);
    #1;

    // add, sub, slt and sltu on the 32-bit unit with 8-bit slices
    run("add_wrap",   32'hFFFF_FFFF, 32'h1,         2'b00, 32'h0,         1'b1, 1'b0, 1'b1);
    run("sub_ovf",    32'h8000_0000, 32'h1,         2'b01, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run("sub_borrow", 32'h0,         32'h1,         2'b01, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run("slt_neg",    32'hFFFF_FFFF, 32'h1,         2'b10, 32'h1,         1'b0, 1'b0, 1'b0);
    run("sltu_big",   32'hFFFF_FFFF, 32'h1,         2'b11, 32'h0,         1'b0, 1'b0, 1'b1);
    run("slt_ovf",    32'h8000_0000, 32'h7FFF_FFFF, 2'b10, 32'h1,         1'b0, 1'b1, 1'b0);

    // Backpressure, and a stray request while the unit is busy
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 2'b00);
    a_in = 32'hFFFF_FFFF;
    b_in = 32'h1;
    op = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {34'h0, v_out_valid}, 35'h1);
      chk("stall_in_ready", {34'h0, v_in_ready}, '0);
      chk("stall_result", v_out, {32'h2345_6789, 3'b000});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_hs_in_ready", {34'h0, v_in_ready}, 35'h1);
    chk("after_hs_out_valid", {34'h0, v_out_valid}, '0);
    @(posedge clk);
    #1;

    // Reset while slice 2 is being processed
    send(32'h1111_1111, 32'h2222_2222, 2'b00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_out_valid", {34'h0, v_out_valid}, '0);
      chk("rst_in_ready", {34'h0, v_in_ready}, '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {34'h0, v_in_ready}, 35'h1);
    chk("post_rst_outputs", v_out, '0);
    @(posedge clk);
    #1;
    run("add_3_4", 32'h3, 32'h4, 2'b00, 32'h7, 1'b0, 1'b0, 1'b0);

    // Random requests with random output stalls on the 32-bit unit
    for (int i = 0; i < 150; i++) begin
      send(rand_operand(32), rand_operand(32), 2'($urandom_range(0, 3)));
      wait_hs(1'b1);
    end

    // Switch to the 16-bit single-slice unit
    out_ready = 1'b1;
    sel = 1'b1;
    pulse_reset();
    run("b_add_ovf",  32'h7FFF, 32'h1, 2'b00, 32'h8000, 1'b0, 1'b1, 1'b0);
    run("b_add_wrap", 32'hFFFF, 32'h1, 2'b00, 32'h0,    1'b1, 1'b0, 1'b1);
    run("b_slt",      32'h8000, 32'h1, 2'b10, 32'h1,    1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      send(rand_operand(16), rand_operand(16), 2'($urandom_range(0, 3)));
      wait_hs(1'b1);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", EW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
